muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit beside the execute-stage ALU. Accepts one M-extension operation per valid/ready handshake, runs a 32-step shift-add multiply or restoring divide under a small state machine, and holds the result until the execute stage takes it. While busy, the execute stage stalls. The unit must discard work on a pipeline flush.

## Interface
- No parameters; data width fixed at 32 (word_t).
- clk_i  in  1  clock
- reset_i  in  1  reset; one clock; asynchronous, active-high
- req_valid_i  in  1  execute stage presents an M-extension op
- req_op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_op1_i  in  32  rs1 operand (alu_op1)
- req_op2_i  in  32  rs2 operand (alu_op2)
- flush_i  in  1  abandon any in-flight or completed op
- req_ready_o  out  1  unit idle, request accepted this cycle if req_valid_i
- busy_o  out  1  op accepted and result not yet consumed; execute-stage stall term
- result_valid_o  out  1  result_o valid
- result_o  out  32  op result
- result_ready_i  in  1  execute stage consumes result this cycle

## Operation
- States: IDLE, MUL, DIV, DONE. Registered: state, 5-bit step counter, 64-bit accumulator/remainder, 32-bit multiplicand/divisor, op, sign flags, result.
- req_ready_o = (state == IDLE). busy_o = (state != IDLE). result_valid_o = (state == DONE).
- Accept: req_valid_i && req_ready_o && !flush_i. Latch op. Latch operands as magnitudes:
  - Signed operands are those of MULH (both), MULHSU (op1 only), DIV/REM (both). All others are unsigned.
  - Record negate flags.
- Multiply (ops 0-3): 32 shift-add steps on magnitudes, giving a 64-bit product.
  - Negate the product if exactly one signed operand is negative.
  - MUL returns bits [31:0]. MULH/MULHSU/MULHU return bits [63:32].
- Divide (ops 4-7): 32 restoring steps on magnitudes.
  - Quotient is negated if operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases go IDLE -> DONE directly, with no iteration:
  - op2 == 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op1.
  - DIV/REM with op1 == 0x80000000 and op2 == 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- MUL/DIV -> DONE when the counter reaches 31. result_o is registered on that transition, sign fix applied.
- DONE -> IDLE when result_ready_i is high. result_o holds its value in IDLE until the next completion.
- flush_i: any state -> IDLE next cycle. Partial or completed result is discarded, result_valid_o drops. Flush beats a simultaneous accept: the request is not taken.
- Reset: state IDLE, counter 0, datapath registers 0.

## Timing
- Reset values: req_ready_o 1, busy_o 0, result_valid_o 0, result_o 0x00000000.
- Accept at edge N:
  - Iterative ops: state MUL/DIV from N+1. result_valid_o high from N+33 (32 cycles in MUL/DIV).
  - Special-case ops: result_valid_o high from N+1.
- Handshake completes at the first edge where result_valid_o && result_ready_i. req_ready_o returns high the following cycle.
- Minimum accept-to-accept spacing:
  - 34 cycles for iterative ops.
  - 2 cycles for special-case ops.
- result_ready_i held high before completion: result_valid_o is high for exactly one cycle.
- result_ready_i low: result_valid_o and result_o hold stable indefinitely.
- reset_i asserted mid-op: outputs take reset values immediately, without waiting for a clock. No result is produced for the aborted op.
- No combinational path from req_* inputs to any output; all outputs decode from registered state.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) -> result_o 0xFFFFFFEB, result_valid_o 33 cycles after accept. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU -> 2.
- Special cases, each with result_valid_o 1 cycle after accept:
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Back-pressure: hold result_ready_i low 10 cycles after completion -> result_valid_o and result_o stable, req_ready_o 0. Raise result_ready_i -> req_ready_o 1 next cycle.
- Flush and reset:
  - flush_i at step 15 of a DIV -> IDLE next cycle, no result_valid_o.
  - flush_i together with req_valid_i in IDLE -> request not accepted.
  - Asynchronous reset_i pulse mid-MUL -> immediate reset values; a new request then completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One M-extension op per valid/ready handshake; 32-step shift-add multiply or
// restoring divide on operand magnitudes, sign fixed up on the final step.
// The result is held in DONE until the execute stage consumes it.
module muldiv_unit (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_op1_i,
    input  logic [31:0] req_op2_i,
    input  logic        flush_i,
    output logic        req_ready_o,
    output logic        busy_o,
    output logic        result_valid_o,
    output logic [31:0] result_o,
    input  logic        result_ready_i
);

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement negate when neg is set, otherwise pass through.
    function automatic word_t magnitude(input word_t v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    state_t      state_r, state_n;
    logic [4:0]  count_r, count_n;
    logic [63:0] acc_r, acc_n;
    word_t       opnd_r, opnd_n;
    logic [2:0]  op_r, op_n;
    logic        neg_res_r, neg_res_n;
    logic        neg_rem_r, neg_rem_n;
    word_t       result_r, result_n;
    logic        ready_r, busy_r, valid_r;

    logic        op1_signed_s, op2_signed_s;
    logic        neg1_s, neg2_s;
    word_t       mag1_s, mag2_s;
    logic        div_zero_s, div_ovf_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_acc_s;
    logic [63:0] prod_s;
    logic [32:0] div_rem_s;
    word_t       div_diff_s;
    logic        div_ge_s;
    logic [63:0] div_acc_s;
    word_t       quot_s, rem_s;

    // Classify the incoming request: operand signedness, magnitudes, special cases.
    always_comb begin
        op1_signed_s = 1'b0;
        op2_signed_s = 1'b0;
        case (req_op_i)
            3'd1, 3'd4, 3'd6: begin
                op1_signed_s = 1'b1;
                op2_signed_s = 1'b1;
            end
            3'd2: begin
                op1_signed_s = 1'b1;
                op2_signed_s = 1'b0;
            end
            default: begin
                op1_signed_s = 1'b0;
                op2_signed_s = 1'b0;
            end
        endcase
        neg1_s     = op1_signed_s & req_op1_i[31];
        neg2_s     = op2_signed_s & req_op2_i[31];
        mag1_s     = magnitude(req_op1_i, neg1_s);
        mag2_s     = magnitude(req_op2_i, neg2_s);
        div_zero_s = (req_op2_i == 32'd0);
        // Only DIV/REM (ops 4 and 6) are signed on op2 among the divide ops.
        div_ovf_s  = req_op_i[2] && op2_signed_s &&
                     (req_op1_i == 32'h8000_0000) && (req_op2_i == 32'hFFFF_FFFF);
    end

    // One iteration of each datapath plus the sign-corrected final values.
    always_comb begin
        // Multiply: multiplier sits in acc low half and shifts out LSB first.
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        mul_acc_s  = {mul_sum_s, acc_r[31:1]};
        prod_s     = neg_res_r ? (64'd0 - mul_acc_s) : mul_acc_s;
        // Divide: shift remainder:quotient left, trial-subtract the divisor.
        div_rem_s  = acc_r[63:31];
        div_ge_s   = (div_rem_s >= {1'b0, opnd_r});
        div_diff_s = div_rem_s[31:0] - opnd_r;
        div_acc_s  = div_ge_s ? {div_diff_s, acc_r[30:0], 1'b1}
                              : {div_rem_s[31:0], acc_r[30:0], 1'b0};
        quot_s     = magnitude(div_acc_s[31:0], neg_res_r);
        rem_s      = magnitude(div_acc_s[63:32], neg_rem_r);
    end

    // Next-state and next-datapath decode; flush overrides everything.
    always_comb begin
        state_n   = state_r;
        count_n   = count_r;
        acc_n     = acc_r;
        opnd_n    = opnd_r;
        op_n      = op_r;
        neg_res_n = neg_res_r;
        neg_rem_n = neg_rem_r;
        result_n  = result_r;
        if (flush_i) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        op_n      = req_op_i;
                        count_n   = 5'd0;
                        neg_res_n = neg1_s ^ neg2_s;
                        neg_rem_n = neg1_s;
                        if (req_op_i[2]) begin
                            if (div_zero_s) begin
                                result_n = req_op_i[1] ? req_op1_i : 32'hFFFF_FFFF;
                                state_n  = ST_DONE;
                            end else if (div_ovf_s) begin
                                result_n = req_op_i[1] ? 32'd0 : 32'h8000_0000;
                                state_n  = ST_DONE;
                            end else begin
                                acc_n   = {32'd0, mag1_s};
                                opnd_n  = mag2_s;
                                state_n = ST_DIV;
                            end
                        end else begin
                            acc_n   = {32'd0, mag2_s};
                            opnd_n  = mag1_s;
                            state_n = ST_MUL;
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_n   = mul_acc_s;
                    count_n = count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        result_n = (op_r == 3'd0) ? prod_s[31:0] : prod_s[63:32];
                        state_n  = ST_DONE;
                    end else begin
                        state_n = ST_MUL;
                    end
                end
                ST_DIV: begin
                    acc_n   = div_acc_s;
                    count_n = count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        result_n = op_r[1] ? rem_s : quot_s;
                        state_n  = ST_DONE;
                    end else begin
                        state_n = ST_DIV;
                    end
                end
                ST_DONE: begin
                    if (result_ready_i) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output-flag registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= ST_IDLE;
            count_r   <= 5'd0;
            acc_r     <= 64'd0;
            opnd_r    <= 32'd0;
            op_r      <= 3'd0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= 32'd0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_n;
            count_r   <= count_n;
            acc_r     <= acc_n;
            opnd_r    <= opnd_n;
            op_r      <= op_n;
            neg_res_r <= neg_res_n;
            neg_rem_r <= neg_rem_n;
            result_r  <= result_n;
            ready_r   <= (state_n == ST_IDLE);
            busy_r    <= (state_n != ST_IDLE);
            valid_r   <= (state_n == ST_DONE);
        end
    end

    assign req_ready_o    = ready_r;
    assign busy_o         = busy_r;
    assign result_valid_o = valid_r;
    assign result_o       = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, back-pressure,
// flush and asynchronous reset, then randomized ops against a reference model.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic [2:0]  req_op_i;
    logic [31:0] req_op1_i;
    logic [31:0] req_op2_i;
    logic        flush_i;
    logic        req_ready_o;
    logic        busy_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic        result_ready_i;

    logic        rand_rr = 1'b0;
    logic        rr_manual = 1'b1;
    logic        rr_rand = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    logic seen = 1'b0;
    logic hs_prev = 1'b0;

    muldiv_unit dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_op_i       (req_op_i),
        .req_op1_i      (req_op1_i),
        .req_op2_i      (req_op2_i),
        .flush_i        (flush_i),
        .req_ready_o    (req_ready_o),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .result_ready_i (result_ready_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #1;
        rr_rand = ($urandom_range(0, 3) != 0);
    end

    assign result_ready_i = rand_rr ? rr_rand : rr_manual;

    // RV32M reference: plain 64-bit arithmetic straight from the ISA rules.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, output logic special);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        special = 1'b0;
        r = 32'd0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) begin r = 32'hFFFF_FFFF; special = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 32'h8000_0000; special = 1'b1; end
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 32'd0) begin r = 32'hFFFF_FFFF; special = 1'b1; end
                else r = a / b;
            end
            3'd6: begin
                if (b == 32'd0) begin r = a; special = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 32'd0; special = 1'b1; end
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin r = a; special = 1'b1; end
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Issue one op; called and returns at posedge+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int   w = 0;
        logic sp;
        exp_t e;
        while (!req_ready_o && w < 300) begin
            @(posedge clk_i); #1;
            w++;
        end
        if (!req_ready_o) begin
            checks++;
            errors++;
            $display("FAIL issue_wait_ready got=0 exp=1");
            return;
        end
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_op1_i   = a;
        req_op2_i   = b;
        @(posedge clk_i); #1;
        e.res = ref_model(op, a, b, sp);
        e.lat = sp ? 1 : 33;
        e.acc = cyc;
        q.push_back(e);
        req_valid_i = 1'b0;
        req_op_i    = 3'($urandom());
        req_op1_i   = $urandom();
        req_op2_i   = $urandom();
    endtask

    task automatic drain();
        int w = 0;
        while ((q.size() != 0 || !req_ready_o) && w < 400) begin
            @(posedge clk_i); #1;
            w++;
        end
        check("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: compares each presented result with the scoreboard head.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (hs_prev) begin
                check("valid_one_cycle_after_handshake", {31'd0, result_valid_o}, 32'd0);
            end
            hs_prev = 1'b0;
            if (result_valid_o) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result got=%h exp=none", result_o);
                end else begin
                    if (!seen) begin
                        check("result_value", result_o, q[0].res);
                        check("result_latency", 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
                        seen = 1'b1;
                    end else begin
                        check("result_stable", result_o, q[0].res);
                    end
                    if (result_ready_i) begin
                        void'(q.pop_front());
                        seen    = 1'b0;
                        hs_prev = 1'b1;
                    end
                end
            end
        end
    end

    logic [2:0]  d_op [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        reset_i     = 1'b1;
        req_valid_i = 1'b0;
        req_op_i    = 3'd0;
        req_op1_i   = 32'd0;
        req_op2_i   = 32'd0;
        flush_i     = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ready", {31'd0, req_ready_o}, 32'd1);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_valid", {31'd0, result_valid_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;

        // Directed test-plan operations, result_ready held high.
        for (int i = 0; i < 12; i++) issue(d_op[i], d_a[i], d_b[i]);
        drain();

        // Back-pressure: hold result_ready low for 10 cycles after completion.
        rr_manual = 1'b0;
        issue(3'd0, 32'd12345, 32'd678);
        begin
            int w = 0;
            while (!result_valid_o && w < 60) begin
                @(posedge clk_i); #1;
                w++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            check("bp_valid_held", {31'd0, result_valid_o}, 32'd1);
            check("bp_ready_low", {31'd0, req_ready_o}, 32'd0);
            check("bp_result_held", result_o, 32'd8369910);
        end
        rr_manual = 1'b1;
        @(posedge clk_i); #1;
        check("bp_ready_after_take", {31'd0, req_ready_o}, 32'd1);
        check("bp_valid_after_take", {31'd0, result_valid_o}, 32'd0);

        // Flush at step 15 of a DIV.
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (15) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        q.delete();
        check("flush_ready", {31'd0, req_ready_o}, 32'd1);
        check("flush_busy", {31'd0, busy_o}, 32'd0);
        check("flush_valid", {31'd0, result_valid_o}, 32'd0);
        repeat (40) @(posedge clk_i);
        #1;

        // Flush together with a request in IDLE: request must not be taken.
        req_valid_i = 1'b1;
        req_op_i    = 3'd4;
        req_op1_i   = 32'd5;
        req_op2_i   = 32'd0;
        flush_i     = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        check("flush_accept_busy", {31'd0, busy_o}, 32'd0);
        check("flush_accept_ready", {31'd0, req_ready_o}, 32'd1);
        repeat (5) @(posedge clk_i);
        #1;

        // Asynchronous reset mid-MUL, then a fresh request.
        issue(3'd0, 32'd3, 32'd5);
        repeat (10) @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        check("areset_ready", {31'd0, req_ready_o}, 32'd1);
        check("areset_busy", {31'd0, busy_o}, 32'd0);
        check("areset_valid", {31'd0, result_valid_o}, 32'd0);
        check("areset_result", result_o, 32'd0);
        q.delete();
        #1;
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        drain();

        // Randomized ops with random back-pressure.
        rand_rr = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
        end
        drain();
        rand_rr = 1'b0;
        repeat (3) @(posedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
